vip_gray_frame_source: RTL and testbench

//  Transmit end of the VIP grayscale pixel-stream interface (vsync/href/clken/8-bit Y).

---
 rtl/vip_gray_frame_source_if.sv | 22 ++
 rtl/vip_gray_frame_source.sv | 228 ++++++++++++++++++++++
 tb/tb_vip_gray_frame_source.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vip_gray_frame_source_if.sv
// VIP grayscale pixel-stream bundle: frame sync, line valid, pixel strobe, 8-bit luma.
// The source drives it through the master modport; a filter chain listens through slave.
interface vip_gray_frame_source_if;
  logic       pre_frame_vsync;
  logic       pre_frame_href;
  logic       pre_frame_clken;
  logic [7:0] pre_img_y;

  modport master (
    output pre_frame_vsync,
    output pre_frame_href,
    output pre_frame_clken,
    output pre_img_y
  );

  modport slave (
    input pre_frame_vsync,
    input pre_frame_href,
    input pre_frame_clken,
    input pre_img_y
  );
endinterface

// File: rtl/vip_gray_frame_source.sv
// Synthetic grayscale frame generator standing in for a camera on the VIP stream.
// Produces vsync / back porch / active lines / h-blank / front porch timing with
// ramp, checker or constant content, optionally corrupted by LFSR salt-and-pepper.
// All outputs are registered from the next-state values, so the output timeline
// lines up cycle-for-cycle with the state timeline (vsync rises the cycle after start).
module vip_gray_frame_source #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int CLKEN_DIV = 1,
  parameter int VS_CYC    = 16,
  parameter int V_BP_CYC  = 64,
  parameter int H_BLANK   = 32,
  parameter int V_FP_CYC  = 64,
  parameter int CHK_BIT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [1:0] pattern,
  input  logic [7:0] const_val,
  input  logic       noise_en,
  output logic       busy,
  output logic       frame_done,
  vip_gray_frame_source_if.master vid
);

  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DW   = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
  localparam int M1   = (VS_CYC > V_BP_CYC) ? VS_CYC : V_BP_CYC;
  localparam int M2   = (H_BLANK > V_FP_CYC) ? H_BLANK : V_FP_CYC;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VS,
    S_VBP,
    S_ACT,
    S_HBL,
    S_VFP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DW-1:0] div, div_nx;
  logic [XW-1:0] x, x_nx;
  logic [YW-1:0] y, y_nx;
  logic          load_cfg;

  // pattern configuration held for the whole frame
  logic [1:0]    pat_q;
  logic [7:0]    cval_q;
  logic          noise_q;

  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic          strobe_nx;
  logic          done_nx;
  logic          chk_x, chk_y;
  logic [7:0]    base_pix, pix_nx;

  // next-state, counter and config-load decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = div;
    x_nx     = x;
    y_nx     = y;
    load_cfg = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_VS;
          cnt_nx   = '0;
          div_nx   = '0;
          x_nx     = '0;
          y_nx     = '0;
          load_cfg = 1'b1;
        end
      end
      S_VS: begin
        if (cnt == CW'(VS_CYC - 1)) begin
          state_nx = S_VBP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_VBP: begin
        if (cnt == CW'(V_BP_CYC - 1)) begin
          state_nx = S_ACT;
          cnt_nx   = '0;
          div_nx   = '0;
          x_nx     = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_ACT: begin
        // x moves on at the end of each pixel period, so it changes right after a strobe
        if (div == DW'(CLKEN_DIV - 1)) begin
          div_nx = '0;
          if (x == XW'(IMG_W - 1)) begin
            cnt_nx   = '0;
            state_nx = (y == YW'(IMG_H - 1)) ? S_VFP : S_HBL;
          end else begin
            x_nx = x + XW'(1);
          end
        end else begin
          div_nx = div + DW'(1);
        end
      end
      S_HBL: begin
        if (cnt == CW'(H_BLANK - 1)) begin
          state_nx = S_ACT;
          cnt_nx   = '0;
          div_nx   = '0;
          x_nx     = '0;
          y_nx     = y + YW'(1);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_VFP: begin
        if (cnt == CW'(V_FP_CYC - 1)) begin
          cnt_nx = '0;
          if (cont) begin
            // back-to-back restart re-samples the pattern inputs
            state_nx = S_VS;
            div_nx   = '0;
            x_nx     = '0;
            y_nx     = '0;
            load_cfg = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // pixel content and stream strobes for the upcoming cycle
  always_comb begin
    strobe_nx = (state_nx == S_ACT) && (div_nx == '0);
    done_nx   = (state_nx == S_VFP) && (cnt_nx == CW'(V_FP_CYC - 1));
    lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    chk_x     = |(x_nx & (XW'(1) << CHK_BIT));
    chk_y     = |(y_nx & (YW'(1) << CHK_BIT));
    base_pix  = '0;
    case (pat_q)
      2'd0: base_pix = 8'(x_nx);
      2'd1: base_pix = 8'(y_nx);
      2'd2: base_pix = (chk_x ^ chk_y) ? 8'hFF : 8'h00;
      default: base_pix = cval_q;
    endcase
    pix_nx = base_pix;
    if (noise_q && (lfsr[4:0] == 5'd0))
      pix_nx = lfsr[5] ? 8'hFF : 8'h00;
  end

  // state and position registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      div   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      div   <= div_nx;
      x     <= x_nx;
      y     <= y_nx;
    end
  end

  // latch pattern inputs at start or continuous restart only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q   <= '0;
      cval_q  <= '0;
      noise_q <= 1'b0;
    end else if (load_cfg) begin
      pat_q   <= pattern;
      cval_q  <= const_val;
      noise_q <= noise_en;
    end
  end

  // noise LFSR: the current value decides the pixel about to strobe, then steps
  always_ff @(posedge clk) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else if (strobe_nx)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // registered stream and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy                <= 1'b0;
      frame_done          <= 1'b0;
      vid.pre_frame_vsync <= 1'b0;
      vid.pre_frame_href  <= 1'b0;
      vid.pre_frame_clken <= 1'b0;
      vid.pre_img_y       <= '0;
    end else begin
      busy                <= (state_nx != S_IDLE);
      frame_done          <= done_nx;
      vid.pre_frame_vsync <= (state_nx == S_VS);
      vid.pre_frame_href  <= (state_nx == S_ACT);
      vid.pre_frame_clken <= strobe_nx;
      // hold between strobes, zero outside the active line
      if (strobe_nx)
        vid.pre_img_y <= pix_nx;
      else if (state_nx != S_ACT)
        vid.pre_img_y <= '0;
    end
  end

endmodule

// File: tb/tb_vip_gray_frame_source.sv
// Bench for vip_gray_frame_source: two instances (CLKEN_DIV 1 and 2) on a small
// 8x4 frame. Expected pixels are queued when a frame is launched and popped by
// per-instance monitors on every strobe; timing is checked via per-frame counters.
module tb_vip_gray_frame_source;
  localparam int IW = 8, IH = 4, VSC = 3, VBP = 4, HB = 5, VFP = 6, CB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_cont, a_noise, a_busy, a_done;
  logic [1:0] a_pat;
  logic [7:0] a_cval;
  logic       b_start, b_cont, b_noise, b_busy, b_done;
  logic [1:0] b_pat;
  logic [7:0] b_cval;

  vip_gray_frame_source_if a_vid();
  vip_gray_frame_source_if b_vid();

  vip_gray_frame_source #(.IMG_W(IW), .IMG_H(IH), .CLKEN_DIV(1), .VS_CYC(VSC),
    .V_BP_CYC(VBP), .H_BLANK(HB), .V_FP_CYC(VFP), .CHK_BIT(CB)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .cont(a_cont), .pattern(a_pat),
    .const_val(a_cval), .noise_en(a_noise), .busy(a_busy), .frame_done(a_done),
    .vid(a_vid));

  vip_gray_frame_source #(.IMG_W(IW), .IMG_H(IH), .CLKEN_DIV(2), .VS_CYC(VSC),
    .V_BP_CYC(VBP), .H_BLANK(HB), .V_FP_CYC(VFP), .CHK_BIT(CB)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .cont(b_cont), .pattern(b_pat),
    .const_val(b_cval), .noise_en(b_noise), .busy(b_busy), .frame_done(b_done),
    .vid(b_vid));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  int exp_a[$], exp_b[$];
  int a_vs, a_href, a_rise, a_clk, a_done_n, a_busy_n, a_zero_viol;
  int b_href, b_clk, b_done_n, b_busy_n, b_pair, b_hold_viol;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // reference pixel with optional noise; advances the model LFSR per strobe
  task automatic push_pix(input int base, input logic noise);
    int v;
    v = base;
    if (noise && m_lfsr[4:0] == 5'd0) v = m_lfsr[5] ? 255 : 0;
    m_lfsr = lfsr_step(m_lfsr);
    exp_a.push_back(v);
  endtask

  // monitor for instance A: scoreboard, frame counters, h-blank length
  initial begin
    logic prev_h, gap_en, h;
    int gap, e;
    prev_h = 1'b0; gap_en = 1'b0; gap = 0;
    forever begin
      @(negedge clk);
      h = a_vid.pre_frame_href;
      if (a_vid.pre_frame_vsync) begin a_vs++; gap_en = 1'b0; end
      if (h) a_href++;
      if (a_busy) a_busy_n++;
      if (a_done) a_done_n++;
      if (!h && a_vid.pre_img_y != 8'd0) a_zero_viol++;
      if (h && !prev_h) begin
        a_rise++;
        if (gap_en) chk("a_hblank_len", gap, HB);
      end
      if (!h) gap++;
      if (!h && prev_h) begin gap_en = 1'b1; gap = 1; end
      prev_h = h;
      if (a_vid.pre_frame_clken) begin
        a_clk++;
        chk("a_clken_in_href", h, 1);
        chk("a_sb_nonempty", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          e = exp_a.pop_front();
          chk("a_pixel", a_vid.pre_img_y, e);
        end
      end
    end
  end

  // monitor for instance B (divided pixel clock)
  initial begin
    logic prev_c;
    logic [7:0] last;
    int e;
    prev_c = 1'b0; last = 8'd0;
    forever begin
      @(negedge clk);
      if (b_vid.pre_frame_href) b_href++;
      if (b_busy) b_busy_n++;
      if (b_done) b_done_n++;
      if (b_vid.pre_frame_clken && prev_c) b_pair++;
      if (b_vid.pre_frame_href && !b_vid.pre_frame_clken && b_vid.pre_img_y != last) b_hold_viol++;
      prev_c = b_vid.pre_frame_clken;
      if (b_vid.pre_frame_clken) begin
        b_clk++;
        last = b_vid.pre_img_y;
        chk("b_sb_nonempty", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          chk("b_pixel", b_vid.pre_img_y, e);
        end
      end
    end
  end

  task automatic clr_stats();
    @(posedge clk);
    a_vs = 0; a_href = 0; a_rise = 0; a_clk = 0; a_done_n = 0; a_busy_n = 0; a_zero_viol = 0;
    b_href = 0; b_clk = 0; b_done_n = 0; b_busy_n = 0; b_pair = 0; b_hold_viol = 0;
  endtask

  task automatic pulse_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (a_done) break;
    end
    if (k == budget) chk(tag, 0, 1);
  endtask

  task automatic wait_href_a(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (a_vid.pre_frame_href) break;
    end
    if (k == budget) chk("a_href_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_cont = 0; a_pat = 0; a_cval = 0; a_noise = 0;
    b_start = 0; b_cont = 0; b_pat = 0; b_cval = 0; b_noise = 0;
    m_lfsr = 16'hACE1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_vsync", a_vid.pre_frame_vsync, 0);
    chk("rst_href", a_vid.pre_frame_href, 0);
    chk("rst_clken", a_vid.pre_frame_clken, 0);
    chk("rst_y", a_vid.pre_img_y, 0);
    chk("rst_b_busy", b_busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // T1: h-ramp timing, plus a start during ACT that must be ignored
    for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) push_pix(x, 1'b0);
    a_pat = 2'd0;
    clr_stats();
    pulse_a();
    wait_href_a(50);
    pulse_a();
    wait_done_a("t1_done_timeout", 400);
    repeat (10) @(negedge clk);
    chk("t1_vsync_cyc", a_vs, VSC);
    chk("t1_href_cyc", a_href, IW * IH);
    chk("t1_href_lines", a_rise, IH);
    chk("t1_clken_cnt", a_clk, IW * IH);
    chk("t1_done_cnt", a_done_n, 1);
    chk("t1_busy_cyc", a_busy_n, 60);
    chk("t1_sb_empty", exp_a.size(), 0);
    chk("t1_y_zero_outside", a_zero_viol, 0);
    chk("t1_idle_busy", a_busy, 0);

    // T2: v-ramp on the divided-clock instance
    for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) exp_b.push_back(y);
    b_pat = 2'd1;
    clr_stats();
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    begin
      int k;
      for (k = 0; k < 600; k++) begin
        @(negedge clk);
        if (b_done) break;
      end
      if (k == 600) chk("t2_done_timeout", 0, 1);
    end
    repeat (10) @(negedge clk);
    chk("t2_busy_cyc", b_busy_n, 92);
    chk("t2_href_cyc", b_href, 2 * IW * IH);
    chk("t2_clken_cnt", b_clk, IW * IH);
    chk("t2_clken_adjacent", b_pair, 0);
    chk("t2_hold_between", b_hold_viol, 0);
    chk("t2_done_cnt", b_done_n, 1);
    chk("t2_sb_empty", exp_b.size(), 0);

    // T3: checker pattern
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++)
        push_pix((((x >> CB) & 1) ^ ((y >> CB) & 1)) != 0 ? 255 : 0, 1'b0);
    a_pat = 2'd2;
    clr_stats();
    pulse_a();
    wait_done_a("t3_done_timeout", 400);
    repeat (5) @(negedge clk);
    chk("t3_sb_empty", exp_a.size(), 0);
    chk("t3_done_cnt", a_done_n, 1);

    // T4: constant + noise from a fresh LFSR, 8 back-to-back frames
    do_reset();
    m_lfsr = 16'hACE1;
    for (int f = 0; f < 8; f++)
      for (int i = 0; i < IW * IH; i++) push_pix(8'h80, 1'b1);
    a_pat = 2'd3; a_cval = 8'h80; a_noise = 1'b1; a_cont = 1'b1;
    clr_stats();
    pulse_a();
    for (int f = 0; f < 7; f++) begin
      wait_done_a("t4_done_timeout", 400);
      @(negedge clk);
      chk("t4_b2b_vsync", a_vid.pre_frame_vsync, 1);
    end
    a_cont = 1'b0;
    wait_done_a("t4_last_timeout", 400);
    repeat (10) @(negedge clk);
    chk("t4_done_cnt", a_done_n, 8);
    chk("t4_sb_empty", exp_a.size(), 0);

    // T5: continuous mode cleared during frame 2
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) push_pix(x, 1'b0);
    a_pat = 2'd0; a_noise = 1'b0; a_cont = 1'b1;
    clr_stats();
    pulse_a();
    wait_done_a("t5_done_timeout", 400);
    @(negedge clk);
    chk("t5_b2b_vsync", a_vid.pre_frame_vsync, 1);
    chk("t5_b2b_busy", a_busy, 1);
    repeat (10) @(negedge clk);
    a_cont = 1'b0;
    wait_done_a("t5_done2_timeout", 400);
    repeat (150) @(negedge clk);
    chk("t5_done_cnt", a_done_n, 2);
    chk("t5_vsync_cyc", a_vs, 2 * VSC);
    chk("t5_idle_busy", a_busy, 0);
    chk("t5_sb_empty", exp_a.size(), 0);

    // T6: reset mid-ACT, then a full noisy h-ramp frame from a reseeded LFSR
    for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) push_pix(x, 1'b0);
    clr_stats();
    pulse_a();
    wait_href_a(50);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_vsync", a_vid.pre_frame_vsync, 0);
    chk("t6_rst_href", a_vid.pre_frame_href, 0);
    chk("t6_rst_clken", a_vid.pre_frame_clken, 0);
    chk("t6_rst_y", a_vid.pre_img_y, 0);
    chk("t6_rst_done", a_done, 0);
    exp_a.delete();
    clr_stats();
    @(negedge clk) rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("t6_no_done_after_rst", a_done_n, 0);
    chk("t6_stays_idle", a_busy, 0);
    m_lfsr = 16'hACE1;
    for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) push_pix(x, 1'b1);
    a_noise = 1'b1;
    clr_stats();
    pulse_a();
    wait_done_a("t6_done_timeout", 400);
    repeat (5) @(negedge clk);
    chk("t6_sb_empty", exp_a.size(), 0);
    chk("t6_clken_cnt", a_clk, IW * IH);
    chk("t6_done_cnt", a_done_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
